// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter: FSM states, error codes,
// well-known keyboard commands and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StSend,
    StAck,
    StWaitIdle
  } ps2_state_e;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrTimeout = 2'b01;
  localparam logic [1:0] ErrNoAck   = 2'b10;

  localparam logic [7:0] CmdSetLeds = 8'hED;
  localparam logic [7:0] CmdEnable  = 8'hF4;
  localparam logic [7:0] CmdReset   = 8'hFF;

  // Parity bit that makes data plus parity contain an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake plus open-drain pad signals of the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       key_clk;
  logic       key_data;
  logic       clk_drive_low;
  logic       data_drive_low;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] error_code;

  modport slave (
    input  tx_data, tx_valid, key_clk, key_data,
    output tx_ready, clk_drive_low, data_drive_low, busy, done, error, error_code
  );

  modport master (
    output tx_data, tx_valid, key_clk, key_data,
    input  tx_ready, clk_drive_low, data_drive_low, busy, done, error, error_code
  );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for an asynchronous PS/2 pad line with a falling-edge strobe.
module ps2_line_sync #(
  parameter logic IdleLevel = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic sync_o,
  output logic fe_o
);

  logic meta_q, sync_q, prev_q;

  // Flops reset to the idle bus level so leaving reset never produces a false edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= IdleLevel;
      sync_q <= IdleLevel;
      prev_q <= IdleLevel;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fe_o   = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: requests the bus, shifts out one command byte on the
// device clock, checks the acknowledge and reports done/error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned InhibitCycles = 3000,
  parameter int unsigned TimeoutCycles = 375000
) (
  input logic           clk_i,
  input logic           rst_i,
  ps2_host_tx_if.slave  ps2_io
);

  localparam int unsigned InhW = $clog2(InhibitCycles);
  localparam int unsigned GapW = $clog2(TimeoutCycles);
  localparam logic [InhW-1:0] InhLast = InhW'(InhibitCycles - 1);
  localparam logic [InhW-1:0] InhData = InhW'(InhibitCycles - 2);
  localparam logic [GapW-1:0] GapLast = GapW'(TimeoutCycles - 1);

  ps2_state_e      state_q;
  logic [9:0]      frame_q;
  logic [3:0]      bit_cnt_q;
  logic [InhW-1:0] inh_cnt_q;
  logic [GapW-1:0] gap_q;
  logic            tx_ready_q, busy_q, clk_drv_q, data_drv_q, done_q, error_q;
  logic [1:0]      err_code_q;

  logic clk_sync, clk_fe, data_sync, data_fe_unused;
  logic lines_idle, timeout_hit;

  ps2_line_sync #(.IdleLevel(1'b1)) u_clk_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .line_i (ps2_io.key_clk),
    .sync_o (clk_sync),
    .fe_o   (clk_fe)
  );

  ps2_line_sync #(.IdleLevel(1'b1)) u_data_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .line_i (ps2_io.key_data),
    .sync_o (data_sync),
    .fe_o   (data_fe_unused)
  );

  assign lines_idle = clk_sync & data_sync;
  // A device clock edge beats the gap limit, and a finished WAIT_IDLE beats it too.
  assign timeout_hit = (state_q inside {StSend, StAck, StWaitIdle}) && !clk_fe &&
                       (gap_q == GapLast) && !(state_q == StWaitIdle && lines_idle);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      inh_cnt_q  <= '0;
      gap_q      <= '0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      clk_drv_q  <= 1'b0;
      data_drv_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ps2_io.tx_valid) begin
            frame_q    <= {1'b1, odd_parity(ps2_io.tx_data), ps2_io.tx_data};
            err_code_q <= ErrNone;
            bit_cnt_q  <= '0;
            inh_cnt_q  <= '0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            clk_drv_q  <= 1'b1;
            state_q    <= StInhibit;
          end
        end
        StInhibit: begin
          inh_cnt_q <= inh_cnt_q + 1'b1;
          // Start bit goes low one cycle before the clock line is released.
          if (inh_cnt_q == InhData) data_drv_q <= 1'b1;
          if (inh_cnt_q == InhLast) begin
            clk_drv_q <= 1'b0;
            state_q   <= StReq;
          end
        end
        StReq: begin
          gap_q   <= '0;
          state_q <= StSend;
        end
        StSend: begin
          if (clk_fe) begin
            gap_q      <= '0;
            data_drv_q <= ~frame_q[bit_cnt_q];
            bit_cnt_q  <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 4'd9) state_q <= StAck;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        StAck: begin
          if (clk_fe) begin
            gap_q <= '0;
            if (!data_sync) begin
              state_q <= StWaitIdle;
            end else begin
              err_code_q <= ErrNoAck;
              error_q    <= 1'b1;
              data_drv_q <= 1'b0;
              tx_ready_q <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= StIdle;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        StWaitIdle: begin
          if (lines_idle) begin
            done_q     <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= StIdle;
          end else if (clk_fe) begin
            gap_q <= '0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (timeout_hit) begin
        err_code_q <= ErrTimeout;
        error_q    <= 1'b1;
        clk_drv_q  <= 1'b0;
        data_drv_q <= 1'b0;
        tx_ready_q <= 1'b1;
        busy_q     <= 1'b0;
        state_q    <= StIdle;
      end
    end
  end

  assign ps2_io.tx_ready       = tx_ready_q;
  assign ps2_io.busy           = busy_q;
  assign ps2_io.clk_drive_low  = clk_drv_q;
  assign ps2_io.data_drive_low = data_drv_q;
  assign ps2_io.done           = done_q;
  assign ps2_io.error          = error_q;
  assign ps2_io.error_code     = err_code_q;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: it sends one command byte, such as LED set 0xED or enable 0xF4, from the calculator core to the keyboard. It is the transmit end of the same Key_Clk/Key_Data link that the existing keyboard receiver decodes. It drives both lines through open-drain "pull low" enables, generates the start, data, odd-parity and stop bits, and checks the device acknowledge. While a frame is in progress, Busy tells the top level to ignore the receiver's output.

## Interface
- INHIBIT_CYCLES, 3000: clock-low request hold, 120 µs at 25 MHz.
- TIMEOUT_CYCLES, 375000: maximum gap between device clock falling edges, 15 ms at 25 MHz.
- CLK_25M  in  1  system clock; all logic runs on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Tx_Data  in  8  command byte; sampled on acceptance.
- Tx_Valid  in  1  request to send Tx_Data.
- Tx_Ready  out  1  high only in IDLE; a transfer is accepted when Tx_Valid and Tx_Ready are both high.
- Key_Clk  in  1  PS/2 clock line as read back from the pad (asynchronous).
- Key_Data  in  1  PS/2 data line as read back from the pad (asynchronous).
- Clk_Drive_Low  out  1  high pulls Key_Clk low; low releases the line.
- Data_Drive_Low  out  1  high pulls Key_Data low; low releases the line.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse on successful, acknowledged completion.
- Error  out  1  one-cycle pulse on failure.
- Error_Code  out  2  00 = none, 01 = timeout, 10 = no acknowledge; held until the next acceptance.

## Operation
- Synchronisation: Key_Clk and Key_Data each pass through a 2-flop synchroniser. A falling edge (fe) is a one-cycle strobe when the previous synchronised Key_Clk is 1 and the current one is 0.
- Frame register: on acceptance it latches {1'b1 stop, parity, Tx_Data}. The parity bit is the XNOR-reduce of Tx_Data, which gives odd parity over data plus parity.
- State IDLE:
  - Both drives are low; Tx_Ready is 1.
  - Acceptance latches the frame, clears Error_Code, clears bit_cnt, and moves to INHIBIT.
  - Tx_Valid while not in IDLE is ignored; it is neither queued nor latched.
- State INHIBIT:
  - Clk_Drive_Low is 1 for INHIBIT_CYCLES cycles.
  - In the last cycle, Data_Drive_Low rises to 1 (the start bit). The next state is REQ.
- State REQ: Clk_Drive_Low returns to 0 and Data_Drive_Low stays 1. The state moves to SEND on the same cycle.
- State SEND:
  - On each fe, bit_cnt increments.
  - Data_Drive_Low becomes the inverse of frame[bit_cnt]:
    - fe 1–8 present the data bits, LSB first;
    - fe 9 presents parity;
    - fe 10 presents the stop bit, which releases the line.
  - After fe 10, the state moves to ACK.
- State ACK: on the next fe (the 11th), synchronised Key_Data is sampled.
  - 0 moves to WAIT_IDLE.
  - 1 sets Error_Code = 10, pulses Error and returns to IDLE.
- State WAIT_IDLE: once synchronised Key_Clk and Key_Data are both 1, Done pulses and the state returns to IDLE.
- Timeout:
  - A gap counter clears on every fe and on entry to SEND.
  - In SEND, ACK or WAIT_IDLE, reaching TIMEOUT_CYCLES releases both drives in that same cycle, sets Error_Code = 01, pulses Error and returns to IDLE.
- Reset: returns the block to IDLE at any point and releases both drives immediately. Reset values:
  - Tx_Ready = 1;
  - Clk_Drive_Low, Data_Drive_Low, Busy, Done and Error = 0;
  - Error_Code = 00.

## Timing
- Acceptance happens on edge N. From edge N+1: Tx_Ready = 0, Busy = 1, Clk_Drive_Low = 1.
- Clock-low duration is exactly INHIBIT_CYCLES cycles. Data_Drive_Low rises in the last of those cycles, one cycle before Key_Clk is released.
- Data_Drive_Low updates 1 cycle after fe, i.e. 3 cycles after the pad edge, counting the synchroniser. This is well inside the device's low half-period.
- The Done or Error pulse and the return to IDLE (Tx_Ready = 1) occur on the same edge. A new acceptance is possible on the following edge.
- An fe arriving in IDLE, INHIBIT or REQ is ignored.
- If the gap counter hits TIMEOUT_CYCLES on the same cycle as an fe, the fe wins.

## Structure
- Package ps2_pkg holds:
  - the state enum: IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE;
  - the Error_Code constants;
  - command constants: 0xED (set LEDs), 0xF4 (enable), 0xFF (reset);
  - an odd-parity function.
- Sub-module ps2_line_sync: a 2-flop synchroniser with falling-edge strobe. It is instantiated for Key_Clk; Key_Data uses the same module, with its strobe left unused.

## Test plan
- Send 0xED; the device model clocks 11 times at a 12 kHz period and acknowledges. Required: sampled bits 0 (start), then 1,0,1,1,0,1,1,1, then parity 1, then stop 1; Done pulses once; Error_Code = 00.
- Send 0x07. Required: parity bit = 0. Send 0x00. Required: parity bit = 1. Both sent back-to-back: the second is accepted the cycle after Tx_Ready returns.
- Send 0xF4 with the device leaving Key_Data high on the 11th clock. Required: Error pulses; Error_Code = 10; no Done; both drives released.
- Send 0xFF with the device stopping clocking after fe 4. Required: exactly TIMEOUT_CYCLES cycles after fe 4, Error pulses with Error_Code = 01 and Tx_Ready = 1.
- Assert Reset during SEND, after fe 6. Required: both drives released immediately and Busy = 0. After reset, 0xED completes normally.
- Hold Tx_Valid with 0x55 throughout a transfer of 0xED. Required: the 0x55 is not accepted until IDLE, then sent as the next frame.
